// File: rtl/vector_load_sequencer.sv
// Vector load sequencer: fetches up to NELEM elements from data memory one
// request at a time, assembles them into a bundle and writes the bundle to a
// vector register with a single-cycle write strobe.
module vector_load_sequencer #(
    parameter int DW    = 32,
    parameter int NELEM = 8,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] stride,
    input  logic [31:0]   vlen,
    input  logic [4:0]    vd,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] write_data_v0,
    output logic [DW-1:0] write_data_v1,
    output logic [DW-1:0] write_data_v2,
    output logic [DW-1:0] write_data_v3,
    output logic [DW-1:0] write_data_v4,
    output logic [DW-1:0] write_data_v5,
    output logic [DW-1:0] write_data_v6,
    output logic [DW-1:0] write_data_v7,
    output logic          VRegWrite,
    output logic [4:0]    write_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int IW = (NELEM > 1) ? $clog2(NELEM) : 1;
    localparam int NW = $clog2(NELEM + 1);
    localparam logic [4:0] VD_MAX = 5'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Effective element count: requested length clamped to the register size.
    function automatic logic [NW-1:0] clamp_len(input logic [31:0] len);
        logic [NW-1:0] r;
        if (len > 32'(NELEM)) begin
            r = NW'(NELEM);
        end else begin
            r = len[NW-1:0];
        end
        return r;
    endfunction

    state_t                   state_r, state_nxt_s;
    logic [AW-1:0]            stride_r, stride_nxt_s;
    logic [AW-1:0]            mem_addr_r, mem_addr_nxt_s;
    logic [4:0]               vd_r, vd_nxt_s;
    logic [4:0]               write_addr_r, write_addr_nxt_s;
    logic [NW-1:0]            n_r, n_nxt_s;
    logic [IW-1:0]            idx_r, idx_nxt_s;
    logic [NELEM-1:0][DW-1:0] elem_r, elem_nxt_s;
    logic                     mem_req_r, mem_req_nxt_s;
    logic                     vreg_write_r, vreg_write_nxt_s;
    logic                     busy_r, busy_nxt_s;
    logic                     done_r, done_nxt_s;
    logic                     err_r, err_nxt_s;

    logic [NW-1:0]            n_start_s;
    logic                     vd_bad_s;
    logic                     accept_s;
    logic                     launch_s;
    logic                     ack_s;
    logic                     last_s;

    assign n_start_s = clamp_len(vlen);
    assign vd_bad_s  = (vd > VD_MAX);
    // A start is only seen in IDLE; anything arriving while busy is dropped.
    assign accept_s  = start && (state_r == ST_IDLE);
    assign launch_s  = accept_s && !vd_bad_s && (n_start_s != {NW{1'b0}});
    // Acks only count while a request is actually outstanding.
    assign ack_s     = mem_req_r && mem_ack && (state_r == ST_REQ);
    assign last_s    = (NW'(idx_r) == (n_r - NW'(1'b1)));

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s && last_s) begin
                    state_nxt_s = ST_WB;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WB: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the datapath and of every registered output.
    always_comb begin
        stride_nxt_s     = stride_r;
        mem_addr_nxt_s   = mem_addr_r;
        vd_nxt_s         = vd_r;
        write_addr_nxt_s = write_addr_r;
        n_nxt_s          = n_r;
        idx_nxt_s        = idx_r;
        elem_nxt_s       = elem_r;
        mem_req_nxt_s    = mem_req_r;
        vreg_write_nxt_s = 1'b0;
        busy_nxt_s       = busy_r;
        done_nxt_s       = 1'b0;
        err_nxt_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    stride_nxt_s   = stride;
                    mem_addr_nxt_s = base_addr;
                    vd_nxt_s       = vd;
                    n_nxt_s        = n_start_s;
                    idx_nxt_s      = {IW{1'b0}};
                    elem_nxt_s     = {(NELEM*DW){1'b0}};
                    if (vd_bad_s) begin
                        err_nxt_s     = 1'b1;
                        done_nxt_s    = 1'b1;
                        mem_req_nxt_s = 1'b0;
                        busy_nxt_s    = 1'b0;
                    end else if (n_start_s == {NW{1'b0}}) begin
                        done_nxt_s    = 1'b1;
                        mem_req_nxt_s = 1'b0;
                        busy_nxt_s    = 1'b0;
                    end else begin
                        mem_req_nxt_s = 1'b1;
                        busy_nxt_s    = 1'b1;
                    end
                end else begin
                    mem_req_nxt_s = 1'b0;
                    busy_nxt_s    = 1'b0;
                end
            end
            ST_REQ: begin
                busy_nxt_s = 1'b1;
                if (ack_s) begin
                    elem_nxt_s[idx_r] = mem_rdata;
                    if (last_s) begin
                        mem_req_nxt_s    = 1'b0;
                        vreg_write_nxt_s = 1'b1;
                        write_addr_nxt_s = vd_r;
                        done_nxt_s       = 1'b1;
                    end else begin
                        mem_req_nxt_s  = 1'b1;
                        idx_nxt_s      = idx_r + IW'(1'b1);
                        mem_addr_nxt_s = mem_addr_r + stride_r;
                    end
                end else begin
                    mem_req_nxt_s = 1'b1;
                end
            end
            ST_WB: begin
                mem_req_nxt_s = 1'b0;
                busy_nxt_s    = 1'b0;
            end
            default: begin
                mem_req_nxt_s = 1'b0;
                busy_nxt_s    = 1'b0;
            end
        endcase
    end

    // Datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stride_r     <= {AW{1'b0}};
            mem_addr_r   <= {AW{1'b0}};
            vd_r         <= 5'd0;
            write_addr_r <= 5'd0;
            n_r          <= {NW{1'b0}};
            idx_r        <= {IW{1'b0}};
            elem_r       <= {(NELEM*DW){1'b0}};
            mem_req_r    <= 1'b0;
            vreg_write_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            stride_r     <= stride_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            vd_r         <= vd_nxt_s;
            write_addr_r <= write_addr_nxt_s;
            n_r          <= n_nxt_s;
            idx_r        <= idx_nxt_s;
            elem_r       <= elem_nxt_s;
            mem_req_r    <= mem_req_nxt_s;
            vreg_write_r <= vreg_write_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            err_r        <= err_nxt_s;
        end
    end

    assign mem_req       = mem_req_r;
    assign mem_addr      = mem_addr_r;
    assign VRegWrite     = vreg_write_r;
    assign write_addr    = write_addr_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign write_data_v0 = elem_r[0];
    assign write_data_v1 = elem_r[1];
    assign write_data_v2 = elem_r[2];
    assign write_data_v3 = elem_r[3];
    assign write_data_v4 = elem_r[4];
    assign write_data_v5 = elem_r[5];
    assign write_data_v6 = elem_r[6];
    assign write_data_v7 = elem_r[7];

endmodule

// File: tb/tb_vector_load_sequencer.sv
// Self-checking bench for vector_load_sequencer: a memory responder with
// configurable wait states, a scoreboard of expected request addresses and
// expected vector writes, and directed load scenarios.
module tb_vector_load_sequencer;

    typedef struct packed {
        logic [4:0]       addr;
        logic [7:0][31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [31:0] stride = 32'd0;
    logic [31:0] vlen = 32'd0;
    logic [4:0]  vd = 5'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata;
    logic [31:0] write_data_v0, write_data_v1, write_data_v2, write_data_v3;
    logic [31:0] write_data_v4, write_data_v5, write_data_v6, write_data_v7;
    logic        VRegWrite;
    logic [4:0]  write_addr;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0][31:0] wdata_s;

    logic [31:0] exp_addr_q[$];
    wb_t         exp_wb_q[$];
    wb_t         wb_head;
    int          checks = 0;
    int          failures = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          ack_cnt = 0;
    int          wb_cnt = 0;
    bit          ack_force = 1'b0;

    always #5 clk = ~clk;

    // Memory returns a recognisable pattern derived from the address.
    assign mem_rdata = mem_addr + 32'hA000;
    assign wdata_s = {write_data_v7, write_data_v6, write_data_v5, write_data_v4,
                      write_data_v3, write_data_v2, write_data_v1, write_data_v0};

    vector_load_sequencer #(.DW(32), .NELEM(8), .AW(32)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
        .vlen(vlen), .vd(vd), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .write_data_v0(write_data_v0), .write_data_v1(write_data_v1),
        .write_data_v2(write_data_v2), .write_data_v3(write_data_v3),
        .write_data_v4(write_data_v4), .write_data_v5(write_data_v5),
        .write_data_v6(write_data_v6), .write_data_v7(write_data_v7),
        .VRegWrite(VRegWrite), .write_addr(write_addr),
        .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory responder and scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            mem_ack = ack_force;
            wait_cnt = 0;
        end else begin
            if (mem_req) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_req", 64'(mem_req), 64'd0);
                end else begin
                    chk("req_addr", 64'(mem_addr), 64'(exp_addr_q[0]));
                end
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    wait_cnt = 0;
                    ack_cnt++;
                    if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
                end else begin
                    mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ack = ack_force;
                wait_cnt = 0;
            end
            if (VRegWrite) begin
                wb_cnt++;
                if (exp_wb_q.size() == 0) begin
                    chk("unexpected_vregwrite", 64'(VRegWrite), 64'd0);
                end else begin
                    wb_head = exp_wb_q.pop_front();
                    chk("write_addr", 64'(write_addr), 64'(wb_head.addr));
                    for (int k = 0; k < 8; k++) begin
                        chk($sformatf("wdata_v%0d", k), 64'(wdata_s[k]), 64'(wb_head.data[k]));
                    end
                end
            end
        end
    end

    // One vector load: builds expectations, drives start, tracks event cycles.
    task automatic run_op(input string name, input logic [31:0] b, input logic [31:0] s,
                          input logic [31:0] l, input logic [4:0] d, input int dly,
                          input int jam_cyc, input int exp_done);
        int n;
        int done_c = -1;
        int req_c = -1;
        int wb_c = -1;
        int err_c = -1;
        bit busy_seen = 1'b0;
        bit ok;
        int acks0;
        int wbs0;
        logic [31:0] a;
        wb_t e;
        n = (l > 32'd8) ? 8 : int'(l);
        ok = (d <= 5'd2) && (n > 0);
        e.addr = d;
        e.data = 256'd0;
        if (ok) begin
            for (int k = 0; k < n; k++) begin
                a = b + s * 32'(k);
                exp_addr_q.push_back(a);
                e.data[k] = a + 32'hA000;
            end
            exp_wb_q.push_back(e);
        end
        ack_delay = dly;
        acks0 = ack_cnt;
        wbs0 = wb_cnt;
        @(negedge clk);
        base_addr = b; stride = s; vlen = l; vd = d; start = 1'b1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (done && done_c < 0) done_c = cyc;
            if (mem_req && req_c < 0) req_c = cyc;
            if (VRegWrite && wb_c < 0) wb_c = cyc;
            if (err && err_c < 0) err_c = cyc;
            if (busy) busy_seen = 1'b1;
            if (cyc == jam_cyc) begin
                start = 1'b1; base_addr = 32'hDEAD0000; stride = 32'h40;
                vlen = 32'd8; vd = 5'd2;
            end else begin
                start = 1'b0;
            end
            if (done_c >= 0 && cyc >= done_c + 3) break;
        end
        start = 1'b0;
        chk({name, "_done_cycle"}, 64'(done_c), 64'(exp_done));
        chk({name, "_vregwrite_cycle"}, 64'(wb_c), ok ? 64'(exp_done) : 64'(-1));
        chk({name, "_err_cycle"}, 64'(err_c), (d > 5'd2) ? 64'd1 : 64'(-1));
        chk({name, "_first_req_cycle"}, 64'(req_c), ok ? 64'd1 : 64'(-1));
        chk({name, "_busy_seen"}, 64'(busy_seen), 64'(ok));
        chk({name, "_captures"}, 64'(ack_cnt - acks0), ok ? 64'(n) : 64'd0);
        chk({name, "_writes"}, 64'(wb_cnt - wbs0), ok ? 64'd1 : 64'd0);
        chk({name, "_addr_q_empty"}, 64'(exp_addr_q.size()), 64'd0);
        chk({name, "_wb_q_empty"}, 64'(exp_wb_q.size()), 64'd0);
        chk({name, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int acks0;
        int wbs0;
        int guard;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_err", 64'({done, err}), 64'd0);
        chk("rst_vregwrite", 64'(VRegWrite), 64'd0);
        chk("rst_addrs", 64'({mem_addr, 27'd0, write_addr}), 64'd0);
        chk("rst_wdata_lo", 64'({write_data_v1, write_data_v0}), 64'd0);
        chk("rst_wdata_hi", 64'({write_data_v7, write_data_v6}), 64'd0);
        rst = 1'b0;

        run_op("contig",   32'h100, 32'd4, 32'd8, 5'd1, 0, 0, 9);
        run_op("short",    32'h40,  32'd8, 32'd3, 5'd0, 0, 0, 4);
        run_op("waits",    32'h800, 32'd4, 32'd2, 5'd2, 2, 0, 7);
        run_op("clamp",    32'h200, 32'd4, 32'd20, 5'd1, 0, 0, 9);
        run_op("vlen0",    32'h200, 32'd4, 32'd0, 5'd1, 0, 0, 1);
        run_op("badvd",    32'h200, 32'd4, 32'd4, 5'd5, 0, 0, 1);
        run_op("wrap",     32'hFFFFFFF8, 32'd4, 32'd4, 5'd2, 0, 0, 5);
        run_op("stride0",  32'h300, 32'd0, 32'd4, 5'd0, 0, 0, 5);
        run_op("jam_busy", 32'h600, 32'd4, 32'd4, 5'd1, 0, 2, 5);
        run_op("jam_wb",   32'h700, 32'd8, 32'd4, 5'd0, 1, 9, 9);

        // Reset in the middle of an 8-element load.
        for (int k = 0; k < 8; k++) exp_addr_q.push_back(32'h500 + 32'(4 * k));
        ack_delay = 0;
        acks0 = ack_cnt;
        wbs0 = wb_cnt;
        @(negedge clk);
        base_addr = 32'h500; stride = 32'd4; vlen = 32'd8; vd = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while ((ack_cnt - acks0) < 3 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("midrst_acks_reached", 64'((ack_cnt - acks0) >= 3), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_flags", 64'({VRegWrite, done, err}), 64'd0);
        chk("midrst_addrs", 64'({mem_addr, 27'd0, write_addr}), 64'd0);
        chk("midrst_wdata", 64'(wdata_s == 256'd0), 64'd1);
        rst = 1'b0;
        exp_addr_q.delete();
        ack_force = 1'b1;
        repeat (2) @(negedge clk);
        ack_force = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_ack_busy", 64'(busy), 64'd0);
        chk("late_ack_wdata", 64'(wdata_s == 256'd0), 64'd1);
        chk("late_ack_writes", 64'(wb_cnt - wbs0), 64'd0);

        // Start together with reset: reset wins.
        rst = 1'b1; start = 1'b1; vd = 5'd1; vlen = 32'd4; base_addr = 32'h900;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", 64'(busy), 64'd0);
        chk("rst_start_mem_req", 64'(mem_req), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
